// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the RV32I fetch stage: FSM state encoding, the NOP word
// and the misalignment helper.
package instr_fetch_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_OUT  = 3'd2,
      S_NPC  = 3'd3,
      S_ERR  = 3'd4
   } if_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   function automatic logic addr_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Architectural PC register with load enable, next-PC alignment handling and the
// pc+4 adder. FETCH_MISALIGN_TRAP_EN selects trap-on-misaligned over masking.
module instr_fetch_pc_reg
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] npc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        npc_trap
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Next PC: hold, or take npc (raw when trapping so the bad target stays visible).
   always_comb begin
      pc_d     = pc_q;
      npc_trap = 1'b0;
      if (load) begin
`ifdef FETCH_MISALIGN_TRAP_EN
         pc_d     = npc;
         npc_trap = addr_misaligned(npc);
`else
         pc_d     = npc & 32'hFFFF_FFFC;
         npc_trap = 1'b0;
`endif
      end else begin
         pc_d     = pc_q;
         npc_trap = 1'b0;
      end
   end

   // PC state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc       = pc_q;
   assign pc_plus4 = pc_q + 32'd4;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage of the multi-cycle RV32I core: req/ack instruction fetch, handoff to
// decode, PC reload from the sequencer. Optional macro: FETCH_MISALIGN_TRAP_EN.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] npc,
   input  logic        npc_valid,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic [31:0] pc_plus4,
   output logic        fetch_err
);

   localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   if_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      inst_q, inst_d;
   logic             err_q, err_d;
   logic             req_q, req_d;
   logic             valid_q, valid_d;

   logic [31:0]      pc_s;
   logic             pc_load_s;
   logic             npc_trap_s;

   assign pc_load_s = (state_q == S_NPC) && npc_valid;

   instr_fetch_pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (pc_load_s),
      .npc      (npc),
      .pc       (pc_s),
      .pc_plus4 (pc_plus4),
      .npc_trap (npc_trap_s)
   );

   // Next-state, timeout counter and instruction latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      inst_d  = inst_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
            cnt_d   = '0;
         end
         S_REQ: begin
            // An ack on the final counted cycle still completes the fetch.
            if (imem_ack) begin
               inst_d  = imem_rdata;
               cnt_d   = '0;
               state_d = S_OUT;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_ERR;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         S_OUT: begin
            if (if_ready) begin
               state_d = S_NPC;
            end else begin
               state_d = S_OUT;
            end
         end
         S_NPC: begin
            if (npc_valid) begin
               if (npc_trap_s) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  state_d = S_REQ;
               end
            end else begin
               state_d = S_NPC;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            err_d   = 1'b1;
            state_d = S_ERR;
         end
      endcase
      req_d   = (state_d == S_REQ);
      valid_d = (state_d == S_OUT);
   end

   // State and output registers; reset drops the request immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         inst_q  <= NOP_INST;
         err_q   <= 1'b0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         inst_q  <= inst_d;
         err_q   <= err_d;
         req_q   <= req_d;
         valid_q <= valid_d;
      end
   end

   assign imem_req  = req_q;
   assign imem_addr = pc_s;
   assign if_valid  = valid_q;
   assign if_pc     = pc_s;
   assign if_inst   = inst_q;
   assign fetch_err = err_q;

endmodule
